// File: rtl/flexpipe_pkg.sv
// Shared flexpipe types: AXI-lite response codes and the config-writer command record.
package flexpipe_pkg;

   localparam int ADDR_WIDTH = 16;

   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] addr;
      logic [31:0]           data;
      logic [3:0]            strb;
   } cfg_cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_WAIT_B
   } cfg_wr_state_e;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/cfg_cmd_fifo.sv
// Synchronous command FIFO; flags come from registered state only, so a pop
// never frees a slot for a push in the same cycle.
module cfg_cmd_fifo
   import flexpipe_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     push,
   input  cfg_cmd_t push_data,
   input  logic     pop,
   output cfg_cmd_t head,
   output logic     full,
   output logic     empty
);

   localparam int PW = $clog2(DEPTH);

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;
   cfg_cmd_t      mem_q [DEPTH];
   logic          do_push, do_pop;

   assign full    = (count_q == (PW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d  = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: entries are only read while count_q says they are valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/cfg_axil_writer.sv
// AXI-lite write initiator: drains a command FIFO, one write outstanding at a time,
// with completion/error statistics and a sticky B-channel timeout flag.
module cfg_axil_writer
   import flexpipe_pkg::*;
#(
   parameter int FIFO_DEPTH    = 4,
   parameter int BRESP_TIMEOUT = 256
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [31:0]           cmd_data,
   input  logic [3:0]            cmd_strb,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
   output logic                  m_axi_awvalid,
   input  logic                  m_axi_awready,
   output logic [31:0]           m_axi_wdata,
   output logic [3:0]            m_axi_wstrb,
   output logic                  m_axi_wvalid,
   input  logic                  m_axi_wready,
   input  logic [1:0]            m_axi_bresp,
   input  logic                  m_axi_bvalid,
   output logic                  m_axi_bready,
   output logic                  busy,
   output logic                  wr_done,
   output logic [15:0]           wr_count,
   output logic [15:0]           err_count,
   output logic                  b_timeout
);

   cfg_wr_state_e         state_q, state_d;
   logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
   logic [31:0]           wdata_q, wdata_d;
   logic [3:0]            wstrb_q, wstrb_d;
   logic                  awvalid_q, awvalid_d;
   logic                  wvalid_q, wvalid_d;
   logic                  wr_done_q, wr_done_d;
   logic [15:0]           wr_count_q, wr_count_d;
   logic [15:0]           err_count_q, err_count_d;
   logic [15:0]           tmo_cnt_q, tmo_cnt_d;
   logic                  b_timeout_q, b_timeout_d;

   cfg_cmd_t fifo_in, fifo_head;
   logic     fifo_full, fifo_empty, fifo_pop;

   assign fifo_in = '{addr: cmd_addr, data: cmd_data, strb: cmd_strb};

   cfg_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (cmd_valid),
      .push_data (fifo_in),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_comb begin
      state_d     = state_q;
      awaddr_d    = awaddr_q;
      wdata_d     = wdata_q;
      wstrb_d     = wstrb_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      wr_done_d   = 1'b0;
      wr_count_d  = wr_count_q;
      err_count_d = err_count_q;
      tmo_cnt_d   = tmo_cnt_q;
      b_timeout_d = b_timeout_q;
      fifo_pop    = 1'b0;
      case (state_q)
         ST_IDLE: if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            awaddr_d  = fifo_head.addr;
            wdata_d   = fifo_head.data;
            wstrb_d   = fifo_head.strb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_SEND;
         end
         ST_SEND: begin
            // Each channel retires on its own handshake; both low means both done.
            awvalid_d = awvalid_q && !m_axi_awready;
            wvalid_d  = wvalid_q && !m_axi_wready;
            if (!awvalid_d && !wvalid_d) begin
               state_d   = ST_WAIT_B;
               tmo_cnt_d = '0;
            end
         end
         ST_WAIT_B: begin
            tmo_cnt_d = sat_inc16(tmo_cnt_q);
            if (tmo_cnt_d == 16'(BRESP_TIMEOUT)) b_timeout_d = 1'b1;
            if (m_axi_bvalid) begin
               wr_done_d  = 1'b1;
               wr_count_d = sat_inc16(wr_count_q);
               if (m_axi_bresp != AXI_RESP_OKAY) err_count_d = sat_inc16(err_count_q);
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         awaddr_q    <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         wr_done_q   <= 1'b0;
         wr_count_q  <= '0;
         err_count_q <= '0;
         tmo_cnt_q   <= '0;
         b_timeout_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         awaddr_q    <= awaddr_d;
         wdata_q     <= wdata_d;
         wstrb_q     <= wstrb_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         wr_done_q   <= wr_done_d;
         wr_count_q  <= wr_count_d;
         err_count_q <= err_count_d;
         tmo_cnt_q   <= tmo_cnt_d;
         b_timeout_q <= b_timeout_d;
      end
   end

   assign cmd_ready     = !fifo_full;
   assign busy          = !fifo_empty || (state_q != ST_IDLE);
   assign m_axi_bready  = (state_q == ST_WAIT_B);
   assign m_axi_awaddr  = awaddr_q;
   assign m_axi_wdata   = wdata_q;
   assign m_axi_wstrb   = wstrb_q;
   assign m_axi_awvalid = awvalid_q;
   assign m_axi_wvalid  = wvalid_q;
   assign wr_done       = wr_done_q;
   assign wr_count      = wr_count_q;
   assign err_count     = err_count_q;
   assign b_timeout     = b_timeout_q;

endmodule
